// File: rtl/cordic_vec_ctrl.sv
// Sequencer for an iterative CORDIC vectoring datapath: load, quadrant
// pre-rotation, ITERATIONS micro-rotations steered by sign(y), then done.
module cordic_vec_ctrl #(
  parameter int WORD_WIDTH = 16,
  parameter int ITERATIONS = 16,
  parameter int ITER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sign_x,
  input  logic                  sign_y,
  output logic                  ready,
  output logic                  busy,
  output logic                  load,
  output logic                  pre_rot,
  output logic                  iter_en,
  output logic [ITER_WIDTH-1:0] iter,
  output logic                  dir,
  output logic                  done
);

  generate
    if (ITERATIONS < 1 || ITERATIONS > (1 << ITER_WIDTH)) begin : g_bad_iterations
      $error("cordic_vec_ctrl: ITERATIONS out of range for ITER_WIDTH");
    end
    if (WORD_WIDTH < 2) begin : g_bad_word_width
      $error("cordic_vec_ctrl: WORD_WIDTH too small for a signed datapath");
    end
  endgenerate

  localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    QUAD = 3'd2,
    ITER = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ITER_WIDTH-1:0]   iter_cnt;
  logic [ITER_WIDTH-1:0]   iter_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_cnt_nxt;
    end
  end

  // The counter only ever advances inside ITER and is cleared on every exit,
  // so it reads 0 in all other states and cannot wrap.
  always_comb begin
    state_nxt    = state;
    iter_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = abort ? IDLE : QUAD;
      end
      QUAD: begin
        state_nxt = abort ? IDLE : ITER;
      end
      ITER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (iter_cnt == ITER_LAST) begin
          state_nxt = DONE;
        end else begin
          iter_cnt_nxt = iter_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes decode from state; pre_rot and dir pass the datapath sign bits
  // through only in the state that consumes them.
  always_comb begin
    ready   = (state == IDLE);
    busy    = (state != IDLE);
    load    = (state == LOAD);
    pre_rot = (state == QUAD) && sign_x;
    iter_en = (state == ITER);
    iter    = iter_cnt;
    dir     = (state == ITER) && sign_y;
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Randomized and directed bench for cordic_vec_ctrl, checked against a
// transaction-level model counting cycles since each accepted start.
module tb_cordic_vec_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, sign_x, sign_y;

  logic       ready16, busy16, load16, pre16, ien16, dir16, done16;
  logic [3:0] iter16;
  logic       ready1, busy1, load1, pre1, ien1, dir1, done1;
  logic [3:0] iter1;

  int n_err = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  bit act16 = 1'b0;
  int k16 = 0;
  bit act1 = 1'b0;
  int k1 = 0;

  always #5 clk = ~clk;

  cordic_vec_ctrl #(.WORD_WIDTH(16), .ITERATIONS(16), .ITER_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sign_x(sign_x), .sign_y(sign_y),
    .ready(ready16), .busy(busy16), .load(load16), .pre_rot(pre16),
    .iter_en(ien16), .iter(iter16), .dir(dir16), .done(done16)
  );

  cordic_vec_ctrl #(.WORD_WIDTH(16), .ITERATIONS(1), .ITER_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sign_x(sign_x), .sign_y(sign_y),
    .ready(ready1), .busy(busy1), .load(load1), .pre_rot(pre1),
    .iter_en(ien1), .iter(iter1), .dir(dir1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Operation model: k counts cycles since the start was accepted.
  // k=0 load, k=1 quadrant, k=2..n+1 micro-rotations, k=n+2 done.
  task automatic step(input int n, inout bit act, inout int k);
    if (rst) begin
      act = 1'b0;
      k   = 0;
    end else if (act) begin
      if (k == n + 2) act = 1'b0;
      else if (abort) act = 1'b0;
      else k++;
    end else if (start && !abort) begin
      act = 1'b1;
      k   = 0;
    end
  endtask

  task automatic check_dut(input string p, input int n, input bit act, input int k,
                           input logic rdy, input logic bsy, input logic ld,
                           input logic pr, input logic ie, input logic [3:0] it,
                           input logic dr, input logic dn);
    bit e_ie;
    e_ie = act && (k >= 2) && (k <= n + 1);
    chk({p, "_ready"},   32'(rdy), 32'(!act));
    chk({p, "_busy"},    32'(bsy), 32'(act));
    chk({p, "_load"},    32'(ld),  32'(act && k == 0));
    chk({p, "_pre_rot"}, 32'(pr),  32'(act && k == 1 && sign_x));
    chk({p, "_iter_en"}, 32'(ie),  32'(e_ie));
    chk({p, "_iter"},    32'(it),  e_ie ? 32'(k - 2) : 32'd0);
    chk({p, "_dir"},     32'(dr),  32'(e_ie && sign_y));
    chk({p, "_done"},    32'(dn),  32'(act && k == n + 2));
  endtask

  always @(posedge clk) begin
    step(16, act16, k16);
    step(1, act1, k1);
    if (rst) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut("n16", 16, act16, k16, ready16, busy16, load16, pre16, ien16, iter16, dir16, done16);
      check_dut("n1",  1,  act1,  k1,  ready1,  busy1,  load1,  pre1,  ien1,  iter1,  dir1,  done1);
    end
  end

  task automatic drive(input logic s, input logic a, input logic sx,
                       input logic sy, input logic r);
    @(posedge clk);
    #1;
    start  = s;
    abort  = a;
    sign_x = sx;
    sign_y = sy;
    rst    = r;
  endtask

  task automatic wait_iter(input logic [3:0] target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (ien16 === 1'b1 && iter16 === target) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int d16;
    int d1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sign_x = 1'b0; sign_y = 1'b0;

    // Reset held with start high must keep both instances idle.
    repeat (3) drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    d16 = -1;
    d1  = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done16 === 1'b1 && d16 < 0) d16 = c;
      if (done1 === 1'b1 && d1 < 0) d1 = c;
    end
    chk("latency16", 32'(d16), 32'd18);
    chk("latency1",  32'(d1),  32'd3);

    // Negative x with alternating sign_y during the micro-rotations.
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 24; i++) drive(0, 0, 1, 1'(i % 2 == 0), 0);

    // Abort at iter 7, then a clean run.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    wait_iter(4'd7, "wait_iter7");
    abort = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_ready", 32'(ready16), 32'd1);
    chk("abort_iter",  32'(iter16),  32'd0);
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 24; i++) drive(0, 0, 0, 1'($urandom % 2), 0);

    // Start held high: back-to-back operations.
    for (int i = 0; i < 60; i++) drive(1, 0, 1'($urandom % 2), 1'($urandom % 2), 0);
    drive(0, 0, 0, 0, 0);
    repeat (22) drive(0, 0, 0, 0, 0);

    // Reset at iter 5.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    wait_iter(4'd5, "wait_iter5");
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_ready", 32'(ready16), 32'd1);
    chk("rst_iter",  32'(iter16),  32'd0);
    chk("rst_iten",  32'(ien16),   32'd0);

    // Abort together with start in IDLE must not launch.
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_start_idle", 32'(ready16), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom % 4 == 0), 1'($urandom % 20 == 0), 1'($urandom % 2),
            1'($urandom % 2), 1'($urandom % 80 == 0));
    end
    drive(0, 0, 0, 0, 0);
    repeat (25) drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
